// File: rtl/hsi_pkg.sv
// Definitions shared by the HSI serial receive and transmit paths:
// state encoding, default frame geometry and the parity polarity.
package hsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } hsi_state_e;

  localparam int HSI_DATA_W = 8;
  localparam int HSI_OVS    = 8;

  // XOR over data plus parity bit equals this value on a good frame.
  localparam logic HSI_PARITY_ODD = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hsi_bit_sync.sv
// Two-flop synchroniser for the serial line plus the mid-bit sample history
// used for the 2-of-3 majority decision.
module hsi_bit_sync
  import hsi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_line,
  input  logic sample_en,
  output logic rx_s,
  output logic majority
);

  logic       meta;
  logic       sync;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 2'b11;
    end else begin
      meta <= rx_line;
      sync <= meta;
      if (sample_en) hist <= {hist[0], sync};
    end
  end

  assign rx_s = sync;
  // The third sample is the live synchronised value on the decision tick.
  assign majority = maj3(hist[1], hist[0], sync);

endmodule

// File: rtl/hsi_rx_deserializer.sv
// HSI serial receive front end: oversampled start/data/parity/stop framing
// with majority voting, reporting each byte as a one-cycle data_valid pulse.
module hsi_rx_deserializer
  import hsi_pkg::*;
#(
  parameter int DATA_W    = HSI_DATA_W,
  parameter int OVS       = HSI_OVS,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_clk_en,
  input  logic              rx_line,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
  localparam logic [2:0] PARITY = ST_PARITY;
  localparam logic [2:0] STOP   = ST_STOP;
  localparam logic [2:0] BREAK  = ST_BREAK;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shift;
  logic              p;
  logic              rx_s;
  logic              majority;
  logic              sample_en;
  logic              decide;
  logic              last;
  logic [CW-1:0]     cnt_next;

  assign sample_en = rx_clk_en && ((cnt == CW'(OVS/2 - 1)) || (cnt == CW'(OVS/2)));
  assign decide    = rx_clk_en && (cnt == CW'(OVS/2 + 1));
  assign last      = (cnt == CW'(OVS - 1));
  assign cnt_next  = last ? '0 : cnt + CW'(1);
  assign busy      = (state != IDLE);

  hsi_bit_sync u_bit_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (rx_line),
    .sample_en (sample_en),
    .rx_s      (rx_s),
    .majority  (majority)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      p          <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (rx_clk_en) begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!rx_s) begin
              state <= START;
              cnt   <= CW'(1);
            end
          end
          START: begin
            cnt <= cnt_next;
            if (decide && majority) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (last) begin
              state <= DATA;
              idx   <= '0;
            end
          end
          DATA: begin
            cnt <= cnt_next;
            if (decide) shift[idx] <= majority;
            if (last) begin
              if (idx == IW'(DATA_W - 1)) begin
                idx   <= '0;
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
          PARITY: begin
            cnt <= cnt_next;
            if (decide) p <= majority;
            if (last) state <= STOP;
          end
          STOP: begin
            cnt <= cnt_next;
            if (decide) begin
              data       <= shift;
              parity_err <= (PARITY_EN != 0) ? ((^shift ^ p) != HSI_PARITY_ODD) : 1'b0;
              frame_err  <= ~majority;
              data_valid <= 1'b1;
              cnt        <= '0;
              // Leaving at mid-stop lets a following start bit be caught early.
              state      <= majority ? IDLE : BREAK;
            end
          end
          BREAK: begin
            cnt <= '0;
            if (rx_s) state <= IDLE;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsi_rx_deserializer.sv
// Directed bench for hsi_rx_deserializer with DATA_W=8, OVS=8, PARITY_EN=1;
// rx_clk_en ticks every 4 clk and the line is driven in whole ticks.
module tb_hsi_rx_deserializer;

  localparam int W   = 8;
  localparam int OVS = 8;

  logic         clk;
  logic         rst;
  logic         rx_clk_en;
  logic         rx_line;
  logic [W-1:0] data;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  int tests_run;
  int tests_failed;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rep_data[$];
  logic         rep_perr[$];
  logic         rep_ferr[$];

  hsi_rx_deserializer #(.DATA_W(W), .OVS(OVS), .PARITY_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_clk_en  (rx_clk_en),
    .rx_line    (rx_line),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // clock / reset / tick generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rx_clk_en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 rx_clk_en = 1'b1;
      @(posedge clk);
      #1 rx_clk_en = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // report monitor
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      rep_data.push_back(data);
      rep_perr.push_back(parity_err);
      rep_ferr.push_back(frame_err);
    end
  end

  // driver tasks
  task automatic wait_tick();
    @(posedge clk);
    while (rx_clk_en !== 1'b1) @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // One bit period; with flip set, the middle majority sample sees ~v.
  task automatic send_bit(input logic v, input logic flip);
    rx_line = v;
    wait_ticks(4);
    if (flip) rx_line = ~v;
    wait_ticks(1);
    rx_line = v;
    wait_ticks(3);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input int noisy_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i], (noisy_bit == i));
    send_bit(p, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    wait_ticks(n * OVS);
  endtask

  task automatic clear_reports();
    rep_data.delete();
    rep_perr.delete();
    rep_ferr.delete();
    exp_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h, required 00", data); end
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
    tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b, required 0", parity_err); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    idle_bits(1);
  endtask

  // 0xA5 has four ones, so the odd-parity bit is 1.
  task automatic test_basic();
    clear_reports();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle_bits(2);
    tests_run++; if (rep_data.size() != 1) begin tests_failed++; $display("FAIL basic_count: got %0d reports, required 1", rep_data.size()); end
    if (rep_data.size() >= 1) begin
      tests_run++; if (rep_data[0] !== exp_q[0]) begin tests_failed++; $display("FAIL basic_data: got %h, required %h", rep_data[0], exp_q[0]); end
      tests_run++; if (rep_perr[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_perr: got %b, required 0", rep_perr[0]); end
      tests_run++; if (rep_ferr[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_ferr: got %b, required 0", rep_ferr[0]); end
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_false_start();
    clear_reports();
    rx_line = 1'b0;
    wait_tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL false_start_busy_hi: got %b, required 1", busy); end
    wait_tick();
    rx_line = 1'b1;
    wait_ticks(OVS);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL false_start_busy_lo: got %b, required 0", busy); end
    idle_bits(2);
    tests_run++; if (rep_data.size() != 0) begin tests_failed++; $display("FAIL false_start_count: got %0d reports, required 0", rep_data.size()); end
  endtask

  // 0x3C has four ones; the correct odd-parity bit is 1, so 0 is the wrong one.
  task automatic test_parity_err();
    clear_reports();
    send_frame(8'h3C, 1'b0, -1);
    idle_bits(2);
    tests_run++; if (rep_data.size() != 1) begin tests_failed++; $display("FAIL perr_count: got %0d reports, required 1", rep_data.size()); end
    if (rep_data.size() >= 1) begin
      tests_run++; if (rep_data[0] !== 8'h3C) begin tests_failed++; $display("FAIL perr_data: got %h, required 3c", rep_data[0]); end
      tests_run++; if (rep_perr[0] !== 1'b1) begin tests_failed++; $display("FAIL perr_flag: got %b, required 1", rep_perr[0]); end
      tests_run++; if (rep_ferr[0] !== 1'b0) begin tests_failed++; $display("FAIL perr_ferr: got %b, required 0", rep_ferr[0]); end
    end
  endtask

  // All-zero frame with parity bit 0: XOR is 0, so parity_err is also 1.
  task automatic test_break();
    clear_reports();
    rx_line = 1'b0;
    wait_ticks(30 * OVS);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL break_busy: got %b, required 1", busy); end
    rx_line = 1'b1;
    wait_ticks(2);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL break_release_busy: got %b, required 0", busy); end
    idle_bits(1);
    send_frame(8'h81, 1'b1, -1);
    idle_bits(2);
    tests_run++; if (rep_data.size() != 2) begin tests_failed++; $display("FAIL break_count: got %0d reports, required 2", rep_data.size()); end
    if (rep_data.size() >= 2) begin
      tests_run++; if (rep_data[0] !== 8'h00) begin tests_failed++; $display("FAIL break_data0: got %h, required 00", rep_data[0]); end
      tests_run++; if (rep_ferr[0] !== 1'b1) begin tests_failed++; $display("FAIL break_ferr0: got %b, required 1", rep_ferr[0]); end
      tests_run++; if (rep_perr[0] !== 1'b1) begin tests_failed++; $display("FAIL break_perr0: got %b, required 1", rep_perr[0]); end
      tests_run++; if (rep_data[1] !== 8'h81) begin tests_failed++; $display("FAIL break_data1: got %h, required 81", rep_data[1]); end
      tests_run++; if ({rep_perr[1], rep_ferr[1]} !== 2'b00) begin tests_failed++; $display("FAIL break_err1: got %b, required 00", {rep_perr[1], rep_ferr[1]}); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_reports();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rx_line = 1'b1;
    wait_ticks(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL midrst_data: got %h, required 00", data); end
    tests_run++; if ({data_valid, parity_err, frame_err} !== 3'b000) begin tests_failed++; $display("FAIL midrst_flags: got %b, required 000", {data_valid, parity_err, frame_err}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    idle_bits(8);
    tests_run++; if (rep_data.size() != 0) begin tests_failed++; $display("FAIL midrst_no_report: got %0d reports, required 0", rep_data.size()); end
    send_frame(8'h5A, 1'b1, -1);
    idle_bits(2);
    tests_run++; if (rep_data.size() != 1) begin tests_failed++; $display("FAIL midrst_count: got %0d reports, required 1", rep_data.size()); end
    if (rep_data.size() >= 1) begin
      tests_run++; if (rep_data[0] !== 8'h5A) begin tests_failed++; $display("FAIL midrst_data2: got %h, required 5a", rep_data[0]); end
      tests_run++; if ({rep_perr[0], rep_ferr[0]} !== 2'b00) begin tests_failed++; $display("FAIL midrst_err2: got %b, required 00", {rep_perr[0], rep_ferr[0]}); end
    end
  endtask

  // 0x12 (two ones) -> p=1; 0x34 (three ones) -> p=0. One mid-bit sample flipped in each.
  task automatic test_back_to_back();
    clear_reports();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1, 3);
    send_frame(8'h34, 1'b0, 5);
    idle_bits(2);
    tests_run++; if (rep_data.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d reports, required 2", rep_data.size()); end
    for (int i = 0; i < 2; i++) begin
      if (rep_data.size() > i) begin
        tests_run++; if (rep_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_data%0d: got %h, required %h", i, rep_data[i], exp_q[i]); end
        tests_run++; if ({rep_perr[i], rep_ferr[i]} !== 2'b00) begin tests_failed++; $display("FAIL b2b_err%0d: got %b, required 00", i, {rep_perr[i], rep_ferr[i]}); end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    rx_line      = 1'b1;
    test_reset();
    test_basic();
    test_false_start();
    test_parity_err();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
